mem_arbiter2: RTL and testbench

//  Two-requester round-robin arbiter sharing one memory port between instruction

---
 rtl/mem_arbiter2.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter2.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter2.sv
// Two-requester round-robin arbiter for the shared instruction/data memory port.
// Holds the grant until mem_ack or watchdog expiry, then forces one IDLE bubble.

module multiplexer2 #(
    parameter int WIDTH = 32
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out
);
    assign out = sel ? in1 : in0;
endmodule

// state | meaning
// IDLE  | no access outstanding; arbitrate on req0/req1 at next posedge
// BUSY  | mem_req high for owner sel; wait for mem_ack or watchdog expiry
module mem_arbiter2 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  sel
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] WD_MAX  = 8'hFF;

    state_t     state, state_nxt;
    logic       sel_nxt;
    logic       last, last_nxt;
    logic       mem_req_nxt;
    logic [7:0] wd_cnt, wd_cnt_nxt;

    logic busy;
    logic wd_expire;
    logic done;

    assign busy      = (state == BUSY);
    // A real ack arriving on the expiry cycle takes priority over the abort.
    assign wd_expire = busy && !mem_ack && (wd_cnt == WD_LAST);
    assign done      = busy && (mem_ack || wd_expire);

    assign ack0  = done && !sel;
    assign ack1  = done && sel;
    assign err   = wd_expire;
    assign rdata = mem_rdata;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            sel     <= 1'b0;
            last    <= 1'b1;
            mem_req <= 1'b0;
            wd_cnt  <= 8'd0;
        end else begin
            state   <= state_nxt;
            sel     <= sel_nxt;
            last    <= last_nxt;
            mem_req <= mem_req_nxt;
            wd_cnt  <= wd_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel;
        last_nxt    = last;
        mem_req_nxt = mem_req;
        wd_cnt_nxt  = wd_cnt;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt   = BUSY;
                    mem_req_nxt = 1'b1;
                    wd_cnt_nxt  = 8'd0;
                    sel_nxt     = (req0 && req1) ? !last : req1;
                end
            end
            BUSY: begin
                if (done) begin
                    state_nxt   = IDLE;
                    mem_req_nxt = 1'b0;
                    last_nxt    = sel;
                end else if (wd_cnt != WD_MAX) begin
                    wd_cnt_nxt = wd_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                mem_req_nxt = 1'b0;
            end
        endcase
    end

    multiplexer2 #(.WIDTH(1)) u_mux_we (
        .sel (sel),
        .in0 (we0),
        .in1 (we1),
        .out (mem_we)
    );

    multiplexer2 #(.WIDTH(ADDR_WIDTH)) u_mux_addr (
        .sel (sel),
        .in0 (addr0),
        .in1 (addr1),
        .out (mem_addr)
    );

    multiplexer2 #(.WIDTH(DATA_WIDTH)) u_mux_wdata (
        .sel (sel),
        .in0 (wdata0),
        .in1 (wdata1),
        .out (mem_wdata)
    );

endmodule

// File: tb/tb_mem_arbiter2.sv
// Bench for mem_arbiter2: directed scenarios plus random traffic, every cycle
// compared against a transaction-level reference model.

module tb_mem_arbiter2;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 15;

    logic          clock;
    logic          reset;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, err;
    logic [DW-1:0] rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          sel;

    mem_arbiter2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
        .clock     (clock),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .err       (err),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .sel       (sel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    // reference model: one outstanding transaction, its owner and its age
    bit m_busy  = 0;
    bit m_owner = 0;
    bit m_last  = 1;
    int m_cycles = 0;

    bit exp_done, exp_err, exp_ack0, exp_ack1;
    bit obs_ack0, obs_ack1, obs_err, obs_mem_req, obs_sel, obs_mem_we;
    logic [DW-1:0] obs_mem_wdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        exp_done = m_busy && (mem_ack || m_cycles == TIMEOUT);
        exp_err  = m_busy && !mem_ack && m_cycles == TIMEOUT;
        exp_ack0 = exp_done && !m_owner;
        exp_ack1 = exp_done && m_owner;
        obs_ack0      = ack0;
        obs_ack1      = ack1;
        obs_err       = err;
        obs_mem_req   = mem_req;
        obs_sel       = sel;
        obs_mem_we    = mem_we;
        obs_mem_wdata = mem_wdata;
        if (chk_en) begin
            chk("ack0", 64'(ack0), 64'(exp_ack0));
            chk("ack1", 64'(ack1), 64'(exp_ack1));
            chk("err", 64'(err), 64'(exp_err));
            chk("mem_req", 64'(mem_req), 64'(m_busy));
            chk("sel", 64'(sel), 64'(m_owner));
            chk("mem_addr", 64'(mem_addr), 64'(m_owner ? addr1 : addr0));
            chk("mem_wdata", 64'(mem_wdata), 64'(m_owner ? wdata1 : wdata0));
            chk("mem_we", 64'(mem_we), 64'(m_owner ? we1 : we0));
            if (exp_done) chk("rdata", 64'(rdata), 64'(mem_rdata));
        end
        @(posedge clock);
        if (!reset) begin
            m_busy  = 0;
            m_owner = 0;
            m_last  = 1;
        end else if (m_busy) begin
            if (exp_done) begin
                m_busy = 0;
                m_last = m_owner;
            end else begin
                m_cycles++;
            end
        end else if (req0 || req1) begin
            m_busy   = 1;
            m_cycles = 1;
            m_owner  = (req0 && req1) ? !m_last : req1;
        end
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int  run, gap, grants;
        bit  got, first_sel, exp_first;

        reset = 0; req0 = 1; req1 = 1; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mem_ack = 0; mem_rdata = 32'h1234_5678;

        // reset held with both requests pending
        step();
        chk_en = 1;
        step();
        chk("t1_mem_req", 64'(obs_mem_req), 64'd0);
        chk("t1_sel", 64'(obs_sel), 64'd0);
        chk("t1_ack", 64'({obs_ack0, obs_ack1, obs_err}), 64'd0);
        reset = 1; req0 = 0; req1 = 0;
        step();

        // single read from port 0, mem_ack three cycles after mem_req
        req0 = 1; addr0 = 32'h100; mem_rdata = 32'hCAFE_0001;
        run = 0; got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            mem_ack = (run == 3);
            step();
            if (obs_mem_req) run++;
            if (obs_ack0) got = 1;
        end
        chk("t2_got_ack", 64'(got), 64'd1);
        chk("t2_busy_len", 64'(run), 64'd4);
        req0 = 0; mem_ack = 0;
        step();
        chk("t2_req_drop", 64'(obs_mem_req), 64'd0);

        // both requesting constantly: alternating grants with one idle bubble
        req0 = 1; req1 = 1; addr0 = 32'h400; addr1 = 32'h800;
        exp_first = !m_last;
        run = 0; gap = 0; grants = 0; first_sel = 0;
        for (int i = 0; i < 80 && grants < 6; i++) begin
            mem_ack = (run == 1);
            step();
            if (obs_mem_req) run++;
            else gap++;
            if (obs_ack0 || obs_ack1) begin
                if (grants == 0) begin
                    first_sel = obs_sel;
                    chk("t3_first", 64'(obs_sel), 64'(exp_first));
                end else begin
                    chk("t3_alt", 64'(obs_sel), 64'(first_sel ^ grants[0]));
                    chk("t3_gap", 64'(gap), 64'd1);
                end
                grants++;
                run = 0; gap = 0;
            end
        end
        chk("t3_grants", 64'(grants), 64'd6);
        req0 = 0; req1 = 0; mem_ack = 0;
        step();

        // write from port 1 that memory never acks: watchdog abort
        req1 = 1; we1 = 1; wdata1 = 32'hDEADBEEF; addr1 = 32'h2000;
        run = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (obs_mem_req) begin
                run++;
                if (run == 1) begin
                    chk("t4_we", 64'(obs_mem_we), 64'd1);
                    chk("t4_wdata", 64'(obs_mem_wdata), 64'hDEADBEEF);
                end
            end
            if (obs_ack1) begin
                got = 1;
                chk("t4_err", 64'(obs_err), 64'd1);
            end
        end
        chk("t4_got_ack", 64'(got), 64'd1);
        chk("t4_busy_len", 64'(run), 64'(TIMEOUT));
        step();
        chk("t4_bubble", 64'(obs_mem_req), 64'd0);
        step();
        chk("t4_regrant", 64'({obs_mem_req, obs_sel}), 64'd3);
        mem_ack = 1;
        step();
        chk("t4_reack", 64'({obs_ack1, obs_err}), 64'd2);
        req1 = 0; we1 = 0; mem_ack = 0;
        step();

        // ack lands on the expiry cycle: normal completion
        req0 = 1; addr0 = 32'h300;
        run = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            mem_ack = (run == TIMEOUT - 1);
            step();
            if (obs_mem_req) run++;
            if (obs_ack0) begin
                got = 1;
                chk("t5_err", 64'(obs_err), 64'd0);
            end
        end
        chk("t5_got_ack", 64'(got), 64'd1);
        chk("t5_busy_len", 64'(run), 64'(TIMEOUT));
        req0 = 0; mem_ack = 0;
        step();

        // reset during BUSY, then stray mem_ack while IDLE
        req0 = 1; addr0 = 32'h500;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (obs_mem_req) got = 1;
        end
        chk("t6_busy", 64'(got), 64'd1);
        reset = 0; req0 = 0; mem_ack = 0;
        step();
        reset = 1; mem_ack = 1;
        step();
        chk("t6_no_ack", 64'({obs_ack0, obs_ack1}), 64'd0);
        chk("t6_mem_req", 64'(obs_mem_req), 64'd0);
        step();
        chk("t6_stray", 64'({obs_ack0, obs_ack1, obs_err}), 64'd0);
        mem_ack = 0;
        step();

        // random traffic; second half starves mem_ack to provoke timeouts
        for (int i = 0; i < 3000; i++) begin
            if (exp_ack0 || !req0) begin
                req0   = ($urandom_range(3) == 0);
                we0    = 1'($urandom_range(1));
                addr0  = $urandom;
                wdata0 = $urandom;
            end
            if (exp_ack1 || !req1) begin
                req1   = ($urandom_range(3) == 0);
                we1    = 1'($urandom_range(1));
                addr1  = $urandom;
                wdata1 = $urandom;
            end
            mem_ack   = ($urandom_range(99) < ((i < 1500) ? 30 : 4));
            mem_rdata = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
